// File: rtl/seven_segment_arbiter.sv
// rtl/seven_segment_arbiter.sv - round-robin arbiter feeding an 8-digit seven-segment panel
// Optional leading-zero blanking is enabled by defining SS_ARB_LEADING_ZERO_BLANK_EN.
module seven_segment_arbiter #(
  parameter int unsigned DWELL_CYCLES = 25000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  req,
  input  logic [31:0] data_0,
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic [31:0] data_3,
  input  logic        hold,
  output logic [3:0]  grant,
  output logic [31:0] disp_value,
  output logic [1:0]  disp_src,
  output logic        disp_valid,
  output logic [7:0]  blank_mask
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [31:0] RELOAD = 32'(DWELL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  grant_q, grant_d;
  logic [31:0] value_q, value_d;
  logic [1:0]  src_q, src_d;
  logic        valid_q, valid_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [31:0] data_sel;
  logic        capture;

  // Scan from farthest to nearest so the nearest requester after ptr_q wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i + 1);
      if (req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    data_sel = data_0;
    case (win_idx)
      2'd0: data_sel = data_0;
      2'd1: data_sel = data_1;
      2'd2: data_sel = data_2;
      2'd3: data_sel = data_3;
      default: data_sel = data_0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = 4'b0000;
    value_d = value_q;
    src_d   = src_q;
    valid_d = valid_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) capture = 1'b1;
      end
      SHOW: begin
        if (!hold) begin
          if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
          end else if (win_found) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d = SHOW;
      cnt_d   = RELOAD;
      ptr_d   = win_idx;
      grant_d = 4'b0001 << win_idx;
      value_d = data_sel;
      src_d   = win_idx;
      valid_d = 1'b1;
    end
  end

  // ptr_q holds the last granted index; 3 makes requester 0 first after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      ptr_q   <= 2'd3;
      grant_q <= 4'b0000;
      value_q <= 32'd0;
      src_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      value_q <= value_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  assign grant      = grant_q;
  assign disp_value = value_q;
  assign disp_src   = src_q;
  assign disp_valid = valid_q;

`ifdef SS_ARB_LEADING_ZERO_BLANK_EN
  logic [7:0] blank_q, blank_d;
  logic       zero_run;

  // Digit k blanks when it and every more-significant nibble are zero.
  always_comb begin
    blank_d  = blank_q;
    zero_run = 1'b1;
    if (capture) begin
      blank_d = 8'h00;
      for (int k = 7; k >= 1; k--) begin
        zero_run   = zero_run & (data_sel[4*k +: 4] == 4'h0);
        blank_d[k] = zero_run;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) blank_q <= 8'h00;
    else       blank_q <= blank_d;
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = 8'h00;
`endif

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// tb/tb_seven_segment_arbiter.sv - directed bench for seven_segment_arbiter
module tb_seven_segment_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] d0, d1, d2, d3;
  logic        hold;

  logic [3:0]  g4, g1;
  logic [31:0] v4, v1;
  logic [1:0]  s4, s1;
  logic        ok4, ok1;
  logic [7:0]  b4, b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_segment_arbiter #(.DWELL_CYCLES(4)) dut4 (
    .CLK(clk), .RESET(rst), .req(req),
    .data_0(d0), .data_1(d1), .data_2(d2), .data_3(d3), .hold(hold),
    .grant(g4), .disp_value(v4), .disp_src(s4), .disp_valid(ok4), .blank_mask(b4)
  );

  seven_segment_arbiter #(.DWELL_CYCLES(1)) dut1 (
    .CLK(clk), .RESET(rst), .req(req),
    .data_0(d0), .data_1(d1), .data_2(d2), .data_3(d3), .hold(hold),
    .grant(g1), .disp_value(v1), .disp_src(s1), .disp_valid(ok1), .blank_mask(b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; hold = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; hold = 1'b0;
    tick();
    checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", g4); end
    checks++; if (v4 !== 32'd0) begin errors++; $display("FAIL reset_value got %h exp 00000000", v4); end
    checks++; if (s4 !== 2'd0) begin errors++; $display("FAIL reset_src got %0d exp 0", s4); end
    checks++; if (ok4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ok4); end
    checks++; if (b4 !== 8'h00) begin errors++; $display("FAIL reset_blank got %h exp 00", b4); end
    rst = 1'b0; req = 4'b0000;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (g4 !== 4'b0000 || ok4 !== 1'b0) begin
        errors++; $display("FAIL idle_quiet got grant=%b valid=%b exp 0000/0", g4, ok4);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g [5];
    logic [31:0] exp_v [5];
    logic [1:0]  exp_s [5];
    exp_g[0] = 4'b0001; exp_v[0] = 32'h11110000; exp_s[0] = 2'd0;
    exp_g[1] = 4'b0010; exp_v[1] = 32'h22220001; exp_s[1] = 2'd1;
    exp_g[2] = 4'b0100; exp_v[2] = 32'h33330002; exp_s[2] = 2'd2;
    exp_g[3] = 4'b1000; exp_v[3] = 32'h44440003; exp_s[3] = 2'd3;
    exp_g[4] = 4'b0001; exp_v[4] = 32'h11110000; exp_s[4] = 2'd0;
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      if (n != 0) begin
        for (int w = 0; w < 3; w++) begin
          tick();
          checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d got %b exp 0000", n, g4); end
        end
      end
      tick();
      checks++; if (g4 !== exp_g[n]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", n, g4, exp_g[n]); end
      checks++; if (v4 !== exp_v[n] || s4 !== exp_s[n]) begin
        errors++; $display("FAIL rr_disp%0d got %h/%0d exp %h/%0d", n, v4, s4, exp_v[n], exp_s[n]);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_single_shot();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    checks++; if (g4 !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", g4); end
    checks++; if (v4 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_value got %h exp deadbeef", v4); end
    checks++; if (ok4 !== 1'b1 || s4 !== 2'd2) begin errors++; $display("FAIL single_valid got %b/%0d exp 1/2", ok4, s4); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (v4 !== 32'hDEADBEEF || ok4 !== 1'b1 || g4 !== 4'b0000) begin
      errors++; $display("FAIL single_retain got %h/%b/%b exp deadbeef/1/0000", v4, ok4, g4);
    end
    // Back in IDLE, a fresh request is granted on the very next edge.
    req = 4'b0001;
    tick();
    req = 4'b0000;
    checks++; if (g4 !== 4'b0001 || v4 !== 32'h11110000) begin
      errors++; $display("FAIL single_idle_regrant got %b/%h exp 0001/11110000", g4, v4);
    end
  endtask

  task automatic test_no_queue();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL noqueue_grant%0d got %b exp 0000", i, g4); end
    end
    checks++; if (s4 !== 2'd0) begin errors++; $display("FAIL noqueue_src got %0d exp 0", s4); end
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0011;
    tick();
    checks++; if (g4 !== 4'b0001) begin errors++; $display("FAIL hold_first got %b exp 0001", g4); end
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (g4 !== 4'b0000 || s4 !== 2'd0) begin
        errors++; $display("FAIL hold_frozen%0d got %b/%0d exp 0000/0", i, g4, s4);
      end
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (g4 !== 4'b0000) begin errors++; $display("FAIL hold_drain%0d got %b exp 0000", i, g4); end
    end
    tick();
    checks++; if (g4 !== 4'b0010 || v4 !== 32'h22220001) begin
      errors++; $display("FAIL hold_regrant got %b/%h exp 0010/22220001", g4, v4);
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    rst = 1'b1; req = 4'b1000;
    tick();
    checks++; if (g4 !== 4'b0000 || v4 !== 32'd0 || s4 !== 2'd0 || ok4 !== 1'b0 || b4 !== 8'h00) begin
      errors++; $display("FAIL midreset_outputs got %b/%h/%0d/%b/%h exp 0000/0/0/0/00", g4, v4, s4, ok4, b4);
    end
    rst = 1'b0;
    tick();
    checks++; if (g4 !== 4'b1000 || s4 !== 2'd3 || v4 !== 32'h44440003) begin
      errors++; $display("FAIL midreset_first got %b/%0d/%h exp 1000/3/44440003", g4, s4, v4);
    end
    req = 4'b0000;
  endtask

  task automatic test_blank();
    logic [7:0] exp_a, exp_b;
`ifdef SS_ARB_LEADING_ZERO_BLANK_EN
    exp_a = 8'hF8; exp_b = 8'hFE;
`else
    exp_a = 8'h00; exp_b = 8'h00;
`endif
    do_reset();
    d0 = 32'h00000A05; req = 4'b0001;
    tick();
    req = 4'b0000;
    checks++; if (b4 !== exp_a) begin errors++; $display("FAIL blank_a05 got %h exp %h", b4, exp_a); end
    for (int i = 0; i < 4; i++) tick();
    d0 = 32'h00000000; req = 4'b0001;
    tick();
    req = 4'b0000;
    checks++; if (b4 !== exp_b || v4 !== 32'd0 || g4 !== 4'b0001) begin
      errors++; $display("FAIL blank_zero got %h/%h/%b exp %h/0/0001", b4, v4, g4, exp_b);
    end
    d0 = 32'h11110000;
  endtask

  task automatic test_dwell1();
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      exp_s = (i % 2 == 0) ? 2'd1 : 2'd3;
      tick();
      checks++; if (g1 !== exp_g || s1 !== exp_s) begin
        errors++; $display("FAIL dwell1_grant%0d got %b/%0d exp %b/%0d", i, g1, s1, exp_g, exp_s);
      end
    end
    req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; hold = 1'b0;
    d0 = 32'h11110000; d1 = 32'h22220001; d2 = 32'hDEADBEEF; d3 = 32'h44440003;
    test_reset();
    test_idle();
    d2 = 32'h33330002;
    test_round_robin();
    d2 = 32'hDEADBEEF;
    test_single_shot();
    test_no_queue();
    test_hold();
    test_reset_mid();
    test_blank();
    test_dwell1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
